// File: rtl/register_file_sb.sv
// Parametrised register file with write-through bypass, RAW busy scoreboard and NZP codes.
// Optional REGFILE_PARITY_EN adds per-register even parity and a par_err output per read port.
module register_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_RD   = 2,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_ld_cc,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_issue_en,
  input  logic [AW-1:0]            i_issue_addr,
  output logic [NUM_REGS-1:0]      o_busy_vec,
`ifdef REGFILE_PARITY_EN
  output logic [NUM_RD-1:0]        o_par_err,
`endif
  output logic [2:0]               o_nzp
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_d;
  logic [2:0]          r_nzp;
  logic [2:0]          w_nzp_d;
  logic                w_msb;
  logic                w_zero;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic r_par [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_par[i] <= 1'b0;
    end else if (i_wr_en) begin
      r_par[i_wr_addr] <= ^i_wr_data;
    end
  end
`endif

  // Set wins over clear: a new producer issued the same cycle the old one retires.
  always_comb begin
    w_busy_d = r_busy;
    if (i_wr_en)    w_busy_d[i_wr_addr]    = 1'b0;
    if (i_issue_en) w_busy_d[i_issue_addr] = 1'b1;
  end

  assign w_msb   = i_wr_data[DATA_W-1];
  assign w_zero  = (i_wr_data == '0);
  assign w_nzp_d = {w_msb, w_zero, !w_msb && !w_zero};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= '0;
      r_nzp  <= 3'b010;
    end else begin
      r_busy <= w_busy_d;
      if (i_ld_cc) r_nzp <= w_nzp_d;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_nzp      = r_nzp;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_rd_addr;
    logic          w_hit;

    assign w_rd_addr = i_rd_addr[k*AW +: AW];
    assign w_hit     = i_wr_en && (i_wr_addr == w_rd_addr);
    assign o_rd_data[k*DATA_W +: DATA_W] = w_hit ? i_wr_data : r_regs[w_rd_addr];
    // Register being written reads as ready since the bypass supplies its data.
    assign o_rd_busy[k] = r_busy[w_rd_addr] && !w_hit;
`ifdef REGFILE_PARITY_EN
    assign o_par_err[k] = !w_hit && (^{r_par[w_rd_addr], r_regs[w_rd_addr]});
`endif
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: default instance plus a 16x32, 3-read-port instance.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, ld_cc, issue_en;
  logic [2:0]  wr_addr, issue_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  busy_vec;
  logic [2:0]  nzp;

  logic        wr_en2, ld_cc2, issue_en2;
  logic [3:0]  wr_addr2, issue_addr2;
  logic [31:0] wr_data2;
  logic [11:0] rd_addr2;
  logic [95:0] rd_data2;
  logic [2:0]  rd_busy2;
  logic [15:0] busy_vec2;
  logic [2:0]  nzp2;
`ifdef REGFILE_PARITY_EN
  logic [1:0]  par_err;
  logic [2:0]  par_err2;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  register_file_sb dut (
    .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_ld_cc(ld_cc), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
    .i_issue_en(issue_en), .i_issue_addr(issue_addr), .o_busy_vec(busy_vec),
`ifdef REGFILE_PARITY_EN
    .o_par_err(par_err),
`endif
    .o_nzp(nzp)
  );

  register_file_sb #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en2), .i_wr_addr(wr_addr2),
    .i_wr_data(wr_data2), .i_ld_cc(ld_cc2), .i_rd_addr(rd_addr2), .o_rd_data(rd_data2),
    .o_rd_busy(rd_busy2), .i_issue_en(issue_en2), .i_issue_addr(issue_addr2),
    .o_busy_vec(busy_vec2),
`ifdef REGFILE_PARITY_EN
    .o_par_err(par_err2),
`endif
    .o_nzp(nzp2)
  );

  task automatic idle();
    wr_en = 0; ld_cc = 0; issue_en = 0; wr_addr = 0; issue_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234; issue_en = 1; issue_addr = 5;
    rd_addr = {3'd5, 3'd3};
    @(posedge clk); #1;
    wr_en = 0; issue_en = 0;
    #1;
    sb_q.push_back(32'h1234);
    sb_q.push_back(32'h20);
    exp = sb_q.pop_front();
    if (rd_data[15:0] !== exp[15:0]) begin
      errors++; $display("FAIL pre_reset_r3 got=%h exp=%h", rd_data[15:0], exp[15:0]);
    end
    checks++;
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL pre_reset_busy got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
    // Mid-cycle assertion: effect must be immediate.
    #1 reset = 1;
    #1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h2);
    exp = sb_q.pop_front();
    if (rd_data !== exp) begin
      errors++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, exp);
    end
    checks++;
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
    exp = sb_q.pop_front();
    if (nzp !== exp[2:0]) begin
      errors++; $display("FAIL reset_nzp got=%b exp=%b", nzp, exp[2:0]);
    end
    checks++;
    // Write and issue during reset are discarded.
    @(negedge clk);
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234; issue_en = 1; issue_addr = 3; ld_cc = 1;
    wr_data = 16'h8000;
    @(negedge clk);
    idle();
    reset = 0;
    #1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h2);
    exp = sb_q.pop_front();
    if (rd_data[15:0] !== exp[15:0]) begin
      errors++; $display("FAIL post_reset_r3 got=%h exp=%h", rd_data[15:0], exp[15:0]);
    end
    checks++;
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL post_reset_busy got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
    exp = sb_q.pop_front();
    if (nzp !== exp[2:0]) begin
      errors++; $display("FAIL post_reset_nzp got=%b exp=%b", nzp, exp[2:0]);
    end
    checks++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF; rd_addr = {3'd1, 3'd2};
    #1;
    sb_q.push_back({16'h0, 16'hBEEF});
    exp = sb_q.pop_front();
    if (rd_data !== exp) begin
      errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data, exp);
    end
    checks++;
    @(negedge clk);
    wr_en = 0;
    #1;
    sb_q.push_back({16'h0, 16'hBEEF});
    exp = sb_q.pop_front();
    if (rd_data !== exp) begin
      errors++; $display("FAIL read_after_write got=%h exp=%h", rd_data, exp);
    end
    checks++;
    rd_addr = {3'd2, 3'd2};
    #1;
    sb_q.push_back({16'hBEEF, 16'hBEEF});
    exp = sb_q.pop_front();
    if (rd_data !== exp) begin
      errors++; $display("FAIL same_addr_ports got=%h exp=%h", rd_data, exp);
    end
    checks++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    issue_en = 1; issue_addr = 4; rd_addr = {3'd0, 3'd4};
    #1;
    sb_q.push_back(32'h0);
    exp = sb_q.pop_front();
    if (rd_busy !== exp[1:0]) begin
      errors++; $display("FAIL issue_same_cycle_busy got=%b exp=%b", rd_busy, exp[1:0]);
    end
    checks++;
    @(negedge clk);
    issue_en = 0;
    #1;
    sb_q.push_back(32'h10); sb_q.push_back(32'h1);
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL issue_busy_vec got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
    exp = sb_q.pop_front();
    if (rd_busy !== exp[1:0]) begin
      errors++; $display("FAIL issue_rd_busy got=%b exp=%b", rd_busy, exp[1:0]);
    end
    checks++;
    @(negedge clk);
    wr_en = 1; wr_addr = 4; wr_data = 16'h0007;
    #1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h7);
    exp = sb_q.pop_front();
    if (rd_busy !== exp[1:0]) begin
      errors++; $display("FAIL write_cycle_rd_busy got=%b exp=%b", rd_busy, exp[1:0]);
    end
    checks++;
    exp = sb_q.pop_front();
    if (rd_data[15:0] !== exp[15:0]) begin
      errors++; $display("FAIL write_cycle_data got=%h exp=%h", rd_data[15:0], exp[15:0]);
    end
    checks++;
    @(negedge clk);
    idle();
    #1;
    sb_q.push_back(32'h0);
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL retire_busy_vec got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
  endtask

  task automatic test_set_clear();
    @(negedge clk);
    idle();
    issue_en = 1; issue_addr = 6;
    @(negedge clk);
    wr_en = 1; wr_addr = 6; wr_data = 16'h0055;
    @(negedge clk);
    idle();
    #1;
    sb_q.push_back(32'h40);
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL set_wins got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
    // Issue to an already-busy register, then retire it.
    issue_en = 1; issue_addr = 6;
    @(negedge clk);
    idle();
    wr_en = 1; wr_addr = 6; wr_data = 16'h0066;
    @(negedge clk);
    idle();
    #1;
    sb_q.push_back(32'h0);
    exp = sb_q.pop_front();
    if (busy_vec !== exp[7:0]) begin
      errors++; $display("FAIL reissue_then_retire got=%h exp=%h", busy_vec, exp[7:0]);
    end
    checks++;
  endtask

  task automatic test_nzp();
    logic [15:0] data_t [4] = '{16'h8000, 16'h0000, 16'h0001, 16'h8000};
    logic        ld_t   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  nzp_t  [4] = '{3'b100, 3'b010, 3'b001, 3'b001};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      wr_data = data_t[i]; ld_cc = ld_t[i];
      sb_q.push_back({29'h0, nzp_t[i]});
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      if (nzp !== exp[2:0]) begin
        errors++; $display("FAIL nzp_%0d got=%b exp=%b", i, nzp, exp[2:0]);
      end
      checks++;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_param();
    @(negedge clk);
    wr_en2 = 1; wr_addr2 = 15; wr_data2 = 32'hFFFF_FFFF; ld_cc2 = 1;
    rd_addr2 = {4'd15, 4'd15, 4'd15};
    @(negedge clk);
    wr_en2 = 0; ld_cc2 = 0;
    #1;
    for (int k = 0; k < 3; k++) sb_q.push_back(32'hFFFF_FFFF);
    sb_q.push_back(32'h4);
    for (int k = 0; k < 3; k++) begin
      exp = sb_q.pop_front();
      if (rd_data2[k*32 +: 32] !== exp) begin
        errors++; $display("FAIL param_port%0d got=%h exp=%h", k, rd_data2[k*32 +: 32], exp);
      end
      checks++;
    end
    exp = sb_q.pop_front();
    if (nzp2 !== exp[2:0]) begin
      errors++; $display("FAIL param_nzp got=%b exp=%b", nzp2, exp[2:0]);
    end
    checks++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    wr_en2 = 0; ld_cc2 = 0; issue_en2 = 0; wr_addr2 = 0; issue_addr2 = 0; wr_data2 = 0;
    rd_addr2 = 0; rd_addr = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_set_clear();
    test_nzp();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor of the LC-3 general-purpose register file.
- Generic width and depth; any number of combinational read ports.
- Write-through bypass from the write port to every read port.
- Per-register busy scoreboard so a pipelined datapath can detect RAW hazards.
- Integrated NZP condition-code register loaded from the writeback value. Sits between decode (read/issue) and writeback.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; must be a power of two, at least 2.
- NUM_RD, 2, number of read ports, at least 1.
- AW, $clog2(NUM_REGS), address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write enable (writeback).
- wr_addr  in  AW  destination register for write.
- wr_data  in  DATA_W  write data.
- ld_cc  in  1  load NZP from wr_data this cycle; independent of wr_en.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has a pending producer.
- issue_en  in  1  mark issue_addr busy (instruction issued with a destination).
- issue_addr  in  AW  register to mark busy.
- busy_vec  out  NUM_REGS  current scoreboard state, bit i = register i busy.
- nzp  out  3  condition codes {N,Z,P}.

Behaviour:
- Reset (async, active-high):
  - all registers go to 0.
  - busy_vec goes to 0.
  - nzp goes to 3'b010 (Z).
  - Effect is immediate on assertion, not at the next edge.
  - An in-flight write or issue in a reset cycle is discarded.
- Write: on posedge clk with wr_en=1, reg[wr_addr] <= wr_data. One write port; no write-enable masking.
- Read: combinational, zero latency.
  - rd_data port k = reg[rd_addr_k], except when wr_en=1 and wr_addr==rd_addr_k: then rd_data port k = wr_data (write-through bypass).
  - Multiple ports reading the same address return identical data.
- Scoreboard, per register i, evaluated each posedge:
  - set_i = issue_en && issue_addr==i
  - clr_i = wr_en && wr_addr==i
  - set_i=1 (regardless of clr_i): busy_i <= 1. Set wins, because a new producer was issued the same cycle the old one retired.
  - else clr_i=1: busy_i <= 0.
  - else: hold.
- rd_busy port k:
  - = busy_vec[rd_addr_k] && !(wr_en && wr_addr==rd_addr_k).
  - A register being written this cycle reads as ready, because bypass supplies the data.
  - Same-cycle issue does not affect rd_busy until the next cycle.
- Condition codes: on posedge with ld_cc=1, nzp <= {wr_data[DATA_W-1], wr_data==0, !wr_data[DATA_W-1] && wr_data!=0}. Exactly one bit is set, always.
- Writes to a non-busy register are legal; busy stays 0.
- Issue to an already-busy register is legal; busy stays 1.
- No X propagation: out-of-range addresses are impossible by construction (AW bits, NUM_REGS = 2^AW).

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit computed from wr_data on write.
  - Adds output port par_err [NUM_RD-1:0]: bit k = 1 when port k's stored word fails the parity check.
  - Bypassed reads never flag.
  - Reset clears parity bits to 0, consistent with zero data.
- Not defined: no parity storage; par_err port absent.

Test Plan:
- Reset: assert reset mid-cycle after writing R3=16'h1234 and issuing R5 -> immediately all rd_data=0, busy_vec=0, nzp=3'b010; R3 reads 0 after release.
- Write/read plus bypass: write R2=16'hBEEF with rd_addr port0=2 in the same cycle -> port0 shows 16'hBEEF combinationally; the next cycle, with wr_en=0, still 16'hBEEF. Port1 reading R1 shows 0.
- Scoreboard: issue R4 -> busy_vec[4]=1 the next cycle; rd_addr=4 gives rd_busy=1. Write R4=16'h0007 -> rd_busy=0 during the write cycle, busy_vec[4]=0 after.
- Simultaneous set/clear: with R6 busy, issue R6 and write R6 the same cycle -> busy_vec[6] remains 1.
- NZP: ld_cc with 16'h8000 -> 3'b100; with 16'h0000 -> 3'b010; with 16'h0001 -> 3'b001. ld_cc=0 with 16'h8000 -> nzp unchanged.
- Parametric: NUM_REGS=16, NUM_RD=3, DATA_W=32; write R15=32'hFFFF_FFFF and read it on all three ports -> all equal; nzp=3'b100 when ld_cc is set.
